// File: rtl/axil_master_cmd.sv
// AXI4-Lite initiator: one command in, one AXI-Lite read or write out, one response back.
// A single transaction is in flight at a time; nonzero BRESP/RRESP values are counted (saturating).
module axil_master_cmd #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 12,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                      axi_clock,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_we,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic [1:0]                resp_code,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [2:0]                m_axil_awprot,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    output logic [DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,
    output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
    output logic [2:0]                m_axil_arprot,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     resp_valid_q, resp_valid_d;
    logic                     resp_we_q, resp_we_d;
    logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
    logic [1:0]               resp_code_q, resp_code_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]        wstrb_q, wstrb_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     bready_q, bready_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic                     err_hit;

    always_comb begin
        state_d      = state_q;
        resp_we_d    = resp_we_q;
        resp_rdata_d = resp_rdata_q;
        resp_code_d  = resp_code_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        err_hit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_we) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; leave once both have gone
                if (m_axil_awready) awvalid_d = 1'b0;
                if (m_axil_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WR_B;
            end
            WR_B: begin
                if (m_axil_bvalid) begin
                    resp_code_d  = m_axil_bresp;
                    resp_rdata_d = '0;
                    resp_we_d    = 1'b1;
                    err_hit      = (m_axil_bresp != 2'b00);
                    state_d      = RESP;
                end
            end
            RD_A: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_D;
                end
            end
            RD_D: begin
                if (m_axil_rvalid) begin
                    resp_code_d  = m_axil_rresp;
                    resp_rdata_d = m_axil_rdata;
                    resp_we_d    = 1'b0;
                    err_hit      = (m_axil_rresp != 2'b00);
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake strobes follow the next state so they are valid the cycle the state is entered
        cmd_ready_d  = (state_d == IDLE);
        bready_d     = (state_d == WR_B);
        rready_d     = (state_d == RD_D);
        resp_valid_d = (state_d == RESP);

        err_count_d = err_count_q;
        if (err_hit && (err_count_q != {ERR_CNT_WIDTH{1'b1}}))
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
    end

    always_ff @(posedge axi_clock) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_rdata_q <= '0;
            resp_code_q  <= 2'b00;
            err_count_q  <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_we_q    <= resp_we_d;
            resp_rdata_q <= resp_rdata_d;
            resp_code_q  <= resp_code_d;
            err_count_q  <= err_count_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_we        = resp_we_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_code      = resp_code_q;
    assign err_count      = err_count_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule
